// File: rtl/dpram_reader.sv
// Burst reader: streams LENGTH words from a synchronous dual-port RAM through a 2-entry FIFO.
// Optional abort input enabled by defining DPRAM_READER_ABORT_EN.
module dpram_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
`ifdef DPRAM_READER_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]   rem_q, rem_d;
  logic                     inflight_q, inflight_d;
  logic                     infl_last_q, infl_last_d;
  logic                     done_q, done_d;

  logic [DATA_WIDTH-1:0]    mem_q [2];
  logic [1:0]               last_q;
  logic                     rd_q, wr_q;
  logic [1:0]               cnt_q;

  logic                     pop;
  logic                     issue;
  logic                     abort_w;

`ifdef DPRAM_READER_ABORT_EN
  assign abort_w = abort & busy;
`else
  assign abort_w = 1'b0;
`endif

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ram_we   = 1'b0;
  assign ram_addr = addr_q;
  assign m_valid  = (cnt_q != 2'd0);
  assign m_data   = mem_q[rd_q];
  assign m_last   = m_valid & last_q[rd_q];
  assign pop      = m_valid & m_ready;

  // A word popped this cycle frees its slot in time for a read issued now.
  assign issue = (state_q == READ) && !abort_w &&
                 (({1'b0, cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign ram_en = issue;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    infl_last_d = issue && (rem_q == {{ADDRESS_WIDTH{1'b0}}, 1'b1});
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d  = base_addr;
            rem_d   = length;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == {{ADDRESS_WIDTH{1'b0}}, 1'b1}) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_w) begin
      state_d    = IDLE;
      done_d     = 1'b1;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      last_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
    end else if (abort_w) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (inflight_q) begin
        mem_q[wr_q]  <= ram_dout;
        last_q[wr_q] <= infl_last_q;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dpram_reader.sv
// Self-checking bench for dpram_reader: stream/address scoreboard plus directed timing tables.
module tb_dpram_reader;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          abort = 1'b0;
  logic          busy, done, ram_en, ram_we, m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] m_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpram_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
`ifdef DPRAM_READER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return 32'hA500_0000 | {16'h0000, a, ~a};
  endfunction

  always @(posedge clk) if (ram_en) ram_dout <= ram_word(ram_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected read addresses and expected stream words of the accepted bursts.
  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0]   exp_word_q[$];
  logic [AW-1:0] addr_log[$];
  int            outstanding = 0;
  int            hs_count = 0;
  bit            stall_seen = 0;

  task automatic model_burst(input logic [AW-1:0] b, input int len);
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(b + AW'(i));
      exp_word_q.push_back({(i == len - 1), ram_word(b + AW'(i))});
    end
  endtask

  always @(negedge clk) begin
    logic pop_now;
    if (!rstn) begin
      exp_addr_q.delete();
      exp_word_q.delete();
      outstanding = 0;
    end else begin
      pop_now = m_valid && m_ready;
      chk("ram_we", ram_we, 1'b0);
      if (ram_en) begin
        addr_log.push_back(ram_addr);
        chk("occupancy_ok", (outstanding - int'(pop_now)) < 2, 1'b1);
        if (exp_addr_q.size() == 0) chk("unexpected_read", 1'b1, 1'b0);
        else chk("ram_addr", ram_addr, exp_addr_q.pop_front());
      end else if (busy && exp_addr_q.size() > 0 && (outstanding - int'(pop_now)) >= 2) begin
        stall_seen = 1;
      end
      if (m_valid) begin
        if (exp_word_q.size() == 0) chk("unexpected_word", 1'b1, 1'b0);
        else begin
          chk("m_data", m_data, exp_word_q[0][DW-1:0]);
          chk("m_last", m_last, exp_word_q[0][DW]);
          if (m_ready) void'(exp_word_q.pop_front());
        end
      end
      if (pop_now) hs_count++;
      outstanding = outstanding + int'(ram_en) - int'(pop_now);
`ifdef DPRAM_READER_ABORT_EN
      if (abort && busy) begin
        exp_addr_q.delete();
        exp_word_q.delete();
        outstanding = 0;
      end
`endif
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input int len, input bit expect_accept);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    length = (AW+1)'(len);
    if (expect_accept) model_burst(b, len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(name, seen, 1'b1);
  endtask

  logic [7:0] t_en, t_valid, t_last, t_done, t_busy;
  logic [AW-1:0] t_addr [8];
  logic [3:0] rdy_pat;
  int hs_base;

  initial begin
    // Reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_ram_addr", ram_addr, '0);
    chk("rst_m_data", m_data, '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    m_ready = 1'b1;

    // Base 0x10, length 4, continuous ready: cycle-exact table (bit0 = first cycle after start)
    t_en = 8'b0000_1111; t_valid = 8'b0011_1100; t_last = 8'b0010_0000;
    t_done = 8'b0100_0000; t_busy = 8'b0011_1111;
    t_addr[0] = 8'h10; t_addr[1] = 8'h11; t_addr[2] = 8'h12; t_addr[3] = 8'h13;
    do_start(8'h10, 4, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t1_ram_en_c%0d", i + 1), ram_en, t_en[i]);
      if (t_en[i]) chk($sformatf("t1_ram_addr_c%0d", i + 1), ram_addr, t_addr[i]);
      chk($sformatf("t1_m_valid_c%0d", i + 1), m_valid, t_valid[i]);
      chk($sformatf("t1_m_last_c%0d", i + 1), m_last, t_last[i]);
      chk($sformatf("t1_done_c%0d", i + 1), done, t_done[i]);
      chk($sformatf("t1_busy_c%0d", i + 1), busy, t_busy[i]);
      if (i == 2) chk("t1_first_word", m_data, 32'hA500_10EF);
      if (i == 5) chk("t1_last_word", m_data, 32'hA500_13EC);
    end
    chk("t1_drained", exp_word_q.size(), 0);

    // Address wrap
    addr_log.delete();
    do_start(8'hFE, 4, 1);
    wait_done("t2_done_timeout", 40);
    chk("t2_nreads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("t2_a0", addr_log[0], 8'hFE);
      chk("t2_a1", addr_log[1], 8'hFF);
      chk("t2_a2", addr_log[2], 8'h00);
      chk("t2_a3", addr_log[3], 8'h01);
    end
    chk("t2_drained", exp_word_q.size(), 0);

    // Zero length
    addr_log.delete();
    do_start(8'h33, 0, 0);
    @(negedge clk);
    chk("t3_done_c1", done, 1'b1);
    chk("t3_busy_c1", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_done_after", done, 1'b0);
      chk("t3_busy_after", busy, 1'b0);
    end
    chk("t3_no_reads", addr_log.size(), 0);

    // Length 8 with ready pattern 1,0,0,1 and an ignored start mid-burst
    rdy_pat = 4'b1001;
    stall_seen = 0;
    hs_base = hs_count;
    do_start(8'h40, 8, 1);
    begin
      bit seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
        m_ready = rdy_pat[k % 4];
        start = (k == 3);
        base_addr = 8'h00;
        length = 9'd5;
        @(negedge clk);
        if (done) seen = 1;
        @(posedge clk); #1;
      end
      chk("t4_done_timeout", seen, 1'b1);
    end
    start = 1'b0;
    m_ready = 1'b1;
    chk("t4_words", hs_count - hs_base, 8);
    chk("t4_drained", exp_word_q.size(), 0);
    chk("t4_stall_seen", stall_seen, 1'b1);

    // Reset mid-burst after 3 words
    hs_base = hs_count;
    do_start(8'h80, 8, 1);
    begin
      bit got3 = 0;
      for (int i = 0; i < 40 && !got3; i++) begin
        @(negedge clk);
        if (hs_count - hs_base >= 3) got3 = 1;
      end
      chk("t5_three_words", got3, 1'b1);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_ram_en", ram_en, 1'b0);
    chk("t5_m_valid", m_valid, 1'b0);
    chk("t5_m_last", m_last, 1'b0);
    chk("t5_ram_addr", ram_addr, '0);
    chk("t5_m_data", m_data, '0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_done", done, 1'b0);
      chk("t5_idle", busy, 1'b0);
    end
    hs_base = hs_count;
    do_start(8'h20, 3, 1);
    wait_done("t5_restart_timeout", 40);
    chk("t5_restart_words", hs_count - hs_base, 3);
    chk("t5_drained", exp_word_q.size(), 0);

`ifdef DPRAM_READER_ABORT_EN
    // Abort after 2 words of 6
    hs_base = hs_count;
    do_start(8'h60, 6, 1);
    begin
      bit got2 = 0;
      for (int i = 0; i < 40 && !got2; i++) begin
        @(negedge clk);
        if (hs_count - hs_base >= 2) got2 = 1;
      end
      chk("t6_two_words", got2, 1'b1);
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("t6_abort_ram_en", ram_en, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t6_m_valid", m_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_done_once", done, 1'b0);
      chk("t6_no_read", ram_en, 1'b0);
      chk("t6_no_valid", m_valid, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
